// File: rtl/ofdm_qpsk_frame_source.sv
// ofdm_qpsk_frame_source
// Maps 2-bit QPSK symbols to complex beats and frames them into N_PTS-beat
// packets for a streaming IFFT sink. Beat 0 of every packet is a zero DC
// null. Beats 1..N_PTS-1 carry one mapped symbol each.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset
//   in_valid   : input symbol valid
//   in_ready   : symbol accepted when in_valid && in_ready (combinational)
//   in_bits    : QPSK symbol, [1] real sign, [0] imag sign (1 = negative)
//   src_valid  : output beat valid
//   src_ready  : downstream ready (ready latency 0)
//   src_sop    : first beat of packet (the DC null)
//   src_eop    : last beat of packet (beat N_PTS-1)
//   src_real   : real part, two's complement, DATA_W bits
//   src_imag   : imaginary part, two's complement, DATA_W bits
//   src_error  : tied to 2'b00
//   fftpts     : tied to N_PTS
//   inverse    : tied to 1 (inverse transform)
//   pkt_count  : packets whose eop beat transferred, wraps
module ofdm_qpsk_frame_source #(
  parameter int N_PTS    = 8,
  parameter int DATA_W   = 8,
  parameter int AMP      = 90,
  parameter int PKTCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_bits,
  output logic                     src_valid,
  input  logic                     src_ready,
  output logic                     src_sop,
  output logic                     src_eop,
  output logic signed [DATA_W-1:0] src_real,
  output logic signed [DATA_W-1:0] src_imag,
  output logic [1:0]               src_error,
  output logic [3:0]               fftpts,
  output logic                     inverse,
  output logic [PKTCNT_W-1:0]      pkt_count
);

  localparam int IDX_W = (N_PTS > 2) ? $clog2(N_PTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);
  localparam logic signed [DATA_W-1:0] AMP_POS = DATA_W'(AMP);

  // QPSK sign bit to amplitude: 0 -> +AMP, 1 -> -AMP.
  function automatic logic signed [DATA_W-1:0] map_qpsk(input logic neg);
    map_qpsk = neg ? -AMP_POS : AMP_POS;
  endfunction

  logic                     r_vld_p0;
  logic                     r_sop_p0;
  logic                     r_eop_p0;
  logic signed [DATA_W-1:0] r_real_p0;
  logic signed [DATA_W-1:0] r_imag_p0;
  logic [IDX_W-1:0]         r_idx;
  logic [PKTCNT_W-1:0]      r_pkt_count;
  logic                     w_load_en;

  // The output register may be (re)loaded when empty or being drained.
  // A symbol is only taken for data beats; the null beat consumes nothing,
  // so the pending symbol stays on in_bits for beat 1.
  always_comb begin
    w_load_en = !r_vld_p0 || src_ready;
    in_ready  = w_load_en && (r_idx != '0);
  end

  // Stage p0: single output register, beat index and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0    <= 1'b0;
      r_sop_p0    <= 1'b0;
      r_eop_p0    <= 1'b0;
      r_real_p0   <= '0;
      r_imag_p0   <= '0;
      r_idx       <= '0;
      r_pkt_count <= '0;
    end else begin
      if (r_vld_p0 && src_ready && r_eop_p0)
        r_pkt_count <= r_pkt_count + PKTCNT_W'(1);
      if (w_load_en) begin
        if (!in_valid) begin
          // Bubble: allowed anywhere, the packet resumes on the next valid.
          r_vld_p0 <= 1'b0;
        end else if (r_idx == '0) begin
          // A packet only opens once data is pending.
          r_vld_p0  <= 1'b1;
          r_sop_p0  <= 1'b1;
          r_eop_p0  <= 1'b0;
          r_real_p0 <= '0;
          r_imag_p0 <= '0;
          r_idx     <= IDX_W'(1);
        end else begin
          r_vld_p0  <= 1'b1;
          r_sop_p0  <= 1'b0;
          r_eop_p0  <= (r_idx == LAST_IDX);
          r_real_p0 <= map_qpsk(in_bits[1]);
          r_imag_p0 <= map_qpsk(in_bits[0]);
          r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign src_valid = r_vld_p0;
  assign src_sop   = r_sop_p0;
  assign src_eop   = r_eop_p0;
  assign src_real  = r_real_p0;
  assign src_imag  = r_imag_p0;
  assign pkt_count = r_pkt_count;
  assign src_error = 2'b00;
  assign fftpts    = 4'(N_PTS);
  assign inverse   = 1'b1;

endmodule

// File: tb/tb_ofdm_qpsk_frame_source.sv
// Testbench for ofdm_qpsk_frame_source. A packet-level reference model
// (beat position within packet, FIFO of accepted symbols, packet counter)
// predicts every transferred beat. A second instance with PKTCNT_W=2
// shares the inputs to exercise counter wrap.
module tb_ofdm_qpsk_frame_source;
  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int AMP = 90;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, src_ready;
  logic [1:0]    in_bits;
  logic          in_ready, src_valid, src_sop, src_eop, inverse;
  logic [DW-1:0] src_real, src_imag;
  logic [1:0]    src_error;
  logic [3:0]    fftpts;
  logic [15:0]   pkt_count;

  logic          in_ready2, src_valid2, src_sop2, src_eop2, inverse2;
  logic [DW-1:0] src_real2, src_imag2;
  logic [1:0]    src_error2;
  logic [3:0]    fftpts2;
  logic [1:0]    pkt_count2;

  ofdm_qpsk_frame_source #(.N_PTS(N), .DATA_W(DW), .AMP(AMP), .PKTCNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop), .src_real(src_real), .src_imag(src_imag),
    .src_error(src_error), .fftpts(fftpts), .inverse(inverse), .pkt_count(pkt_count));

  ofdm_qpsk_frame_source #(.N_PTS(N), .DATA_W(DW), .AMP(AMP), .PKTCNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_bits(in_bits), .src_valid(src_valid2), .src_ready(src_ready),
    .src_sop(src_sop2), .src_eop(src_eop2), .src_real(src_real2), .src_imag(src_imag2),
    .src_error(src_error2), .fftpts(fftpts2), .inverse(inverse2), .pkt_count(pkt_count2));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] sym_q[$];
  int         k = 0;        // position of the next beat to transfer in its packet
  int         pkts = 0;     // packets completed
  int         n_cyc = 0;
  int         n_xfer = 0;
  bit         last_acc;
  bit         last_xfer;
  bit         held;
  logic [DW-1:0] h_real, h_imag;
  logic       h_sop, h_eop;
  logic [1:0] syms[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int mapv(input logic neg);
    return neg ? -AMP : AMP;
  endfunction

  // One clock: entered and left at a falling edge with inputs already driven.
  task automatic tick();
    logic [1:0] s;
    #1;
    last_acc  = in_valid && in_ready;
    last_xfer = src_valid && src_ready;
    held = 1'b0;
    if (reset) begin
      sym_q.delete();
      k = 0;
      pkts = 0;
      last_acc = 1'b0;
      last_xfer = 1'b0;
    end else begin
      if (src_valid && !src_ready) begin
        chk("in_ready_during_stall", in_ready, 0);
        held = 1'b1;
        h_real = src_real; h_imag = src_imag; h_sop = src_sop; h_eop = src_eop;
      end
      chk("dut2_in_ready_match", in_ready2, in_ready);
      if (last_xfer) begin
        n_xfer++;
        if (k == 0) begin
          chk("null_sop", src_sop, 1);
          chk("null_eop", src_eop, 0);
          chk("null_real", $signed(src_real), 0);
          chk("null_imag", $signed(src_imag), 0);
        end else begin
          chk("symbol_pending", (sym_q.size() > 0), 1);
          s = (sym_q.size() > 0) ? sym_q.pop_front() : 2'bxx;
          chk("data_sop", src_sop, 0);
          chk("data_eop", src_eop, (k == N-1));
          chk("data_real", $signed(src_real), mapv(s[1]));
          chk("data_imag", $signed(src_imag), mapv(s[0]));
        end
        if (k == N-1) pkts++;
        k = (k + 1) % N;
      end
      if (last_acc) sym_q.push_back(in_bits);
    end
    @(posedge clk);
    @(negedge clk);
    n_cyc++;
    chk("pkt_count", pkt_count, pkts % 65536);
    chk("pkt_count_w2", pkt_count2, pkts % 4);
    chk("src_error", src_error2 | src_error, 0);
    chk("fftpts", fftpts, N);
    chk("inverse", inverse & inverse2, 1);
    if (held) begin
      chk("stall_valid", src_valid, 1);
      chk("stall_real", src_real, h_real);
      chk("stall_imag", src_imag, h_imag);
      chk("stall_sop", src_sop, h_sop);
      chk("stall_eop", src_eop, h_eop);
    end
  endtask

  // mode 0: continuous, 1: 3-cycle stall at beat 4, 2: in_valid toggles, 3: random
  task automatic run_stream(input int n, input int mode, input int budget);
    int i = 0, cyc = 0, stall_left = 0;
    bit stalled_done = 0;
    while ((i < n || sym_q.size() > 0 || src_valid) && cyc < budget) begin
      if (i < n) begin
        in_valid = (mode == 2) ? (cyc % 2 == 0) :
                   (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_bits  = syms[i];
      end else begin
        in_valid = 1'b0;
        in_bits  = 2'($urandom);
      end
      src_ready = 1'b1;
      if (mode == 1 && !stalled_done && src_valid && k == 4) begin
        stall_left = 3;
        stalled_done = 1;
      end
      if (stall_left > 0) begin
        src_ready = 1'b0;
        stall_left--;
      end
      if (mode == 3) src_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    src_ready = 1'b1;
    chk("stream_in_budget", (cyc < budget), 1);
    chk("all_symbols_taken", i, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_valid", src_valid, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_real", src_real, 0);
    chk("rst_imag", src_imag, 0);
    chk("rst_pkt", pkt_count, 0);
  endtask

  task automatic rand_syms();
    for (int j = 0; j < 256; j++) syms[j] = 2'($urandom);
  endtask

  initial begin
    int first_x, cnt_x, i;
    reset = 1'b1; in_valid = 1'b0; src_ready = 1'b1; in_bits = 2'b00;
    @(negedge clk);
    do_reset();

    // 1: one packet of directed symbols
    syms[0] = 2'b00; syms[1] = 2'b01; syms[2] = 2'b10; syms[3] = 2'b11;
    syms[4] = 2'b00; syms[5] = 2'b01; syms[6] = 2'b10;
    run_stream(7, 0, 40);
    chk("t1_pkt_count", pkt_count, 1);

    // 2: backpressure at beat 4
    rand_syms();
    run_stream(7, 1, 40);
    chk("t2_pkt_count", pkt_count, 2);

    // 3: in_valid toggling
    rand_syms();
    run_stream(7, 2, 60);
    chk("t3_pkt_count", pkt_count, 3);

    // 4: reset after 4 beats of a packet
    rand_syms();
    i = 0;
    cnt_x = 0;
    while (k != 4 && cnt_x < 30) begin
      in_valid = 1'b1; in_bits = syms[i]; src_ready = 1'b1;
      tick();
      if (last_acc) i++;
      cnt_x++;
    end
    chk("t4_reached_beat4", k, 4);
    do_reset();
    rand_syms();
    run_stream(7, 0, 40);
    chk("t4_pkt_after_reset", pkt_count, 1);

    // 5: 14 symbols back-to-back, 16 contiguous beats
    do_reset();
    rand_syms();
    first_x = -1; cnt_x = 0; i = 0;
    while ((i < 14 || src_valid) && n_cyc < 100000 && cnt_x < 40) begin
      in_valid = (i < 14); in_bits = syms[i]; src_ready = 1'b1;
      tick();
      if (last_acc) i++;
      if (last_xfer) begin
        if (first_x < 0) first_x = n_cyc;
        cnt_x++;
      end
    end
    in_valid = 1'b0;
    chk("t5_beats", cnt_x, 16);
    chk("t5_no_idle", n_cyc - first_x + 1, 16);
    chk("t5_pkt_count", pkt_count, 2);

    // 6: counter wrap on the narrow instance, random handshakes
    do_reset();
    rand_syms();
    run_stream(35, 3, 400);
    chk("t6_pkt_w2", pkt_count2, 1);
    chk("t6_pkt_w16", pkt_count, 5);

    // Longer random soak
    rand_syms();
    run_stream(200, 3, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
